tl_phase_scheduler: RTL and testbench
=====================================

Name: tl_phase_scheduler

Overview:
Junction phase scheduler that shares right-of-way at one main/side/pedestrian crossing.
- Latches side-road sensor and pedestrian button requests, then arbitrates between them.
- Sequences timed green/yellow/all-red/walk phases and drives the lamp codes directly.
- Sits between the raw sensor/button inputs and the lamp drivers; main road is the default owner.

Parameters:
MAIN_MIN_GREEN, 8, minimum cycles in MAIN_G before any request is served
YELLOW_T, 3, cycles in MAIN_Y and SIDE_Y
ALL_RED_T, 1, cycles in each all-red clearance state
SIDE_GREEN_T, 6, cycles in SIDE_G
WALK_T, 5, cycles in PED_WALK
SENSE_CYCLES, 3, consecutive side_s-high cycles needed to register a side request
CNT_W, 4, phase timer width; every duration must be >= 1 and <= 2^CNT_W-1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
side_s  in  1  side-road vehicle sensor (level)
ped_req  in  1  pedestrian button; any high cycle is a request
main_l  out  2  main lamp: 10 green, 01 yellow, 00 red
side_l  out  2  side lamp, same coding
ped_l  out  1  walk lamp
side_wait  out  1  latched side request pending
ped_wait  out  1  latched pedestrian request pending
ped_ack  out  1  one-cycle pulse on the first cycle of PED_WALK
phase  out  3  current state encoding

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
  - Reset values: state MAIN_G, main_l=10, side_l=00, ped_l=0, side_wait=0, ped_wait=0, ped_ack=0.
  - Timer, sense counter and last_served clear to 0; last_served=0 means PED.
- Register timing: all outputs are registered. Lamps decode from next-state, so lamps change on the same edge as phase.
- States and transitions: timer clears on state entry; a duration D means exactly D cycles in the state.
  - MAIN_G (main 10, side 00): go to MAIN_Y when timer >= MAIN_MIN_GREEN-1 and (side_wait|ped_wait). Otherwise hold; timer saturates.
  - MAIN_G exit: latch svc. If only one flag is set, svc is that requester. If both are set, svc is the opposite of last_served; last_served updates to svc.
  - MAIN_Y (main 01) -> CLR_OUT after YELLOW_T.
  - CLR_OUT (all 00) -> SIDE_G if svc=SIDE, else PED_WALK, after ALL_RED_T.
  - SIDE_G (side 10) -> SIDE_Y after SIDE_GREEN_T.
  - SIDE_Y (side 01) -> CLR_IN after YELLOW_T.
  - PED_WALK (ped_l=1, main/side 00) -> CLR_IN after WALK_T.
  - CLR_IN (all 00) -> MAIN_G after ALL_RED_T.
  - Illegal encodings -> MAIN_G next cycle.
- Side request:
  - The sense counter increments while side_s=1 and saturates at SENSE_CYCLES; it clears when side_s=0.
  - Reaching SENSE_CYCLES sets side_wait. side_wait clears on the entry edge of SIDE_G.
  - A side_s pulse shorter than SENSE_CYCLES is ignored.
- Ped request: ped_req=1 sets ped_wait. ped_wait clears on the entry edge of PED_WALK.
- Request coinciding with its service:
  - A request arriving on the same edge as entry to its own service phase is absorbed (clear wins).
  - Requests during SIDE_G/PED_WALK after that edge set the flag again.
- Other requester: its flag is untouched while the other requester is served; it waits through the next MAIN_G minimum.
- ped_ack: high only in the first PED_WALK cycle.
- Reset mid-phase: immediate return to the reset values; no yellow or clearance is run.
- Safety invariant: main_l and side_l are never both non-00. ped_l=1 implies main_l=side_l=00.

Optional Feature:
Macro TL_PREEMPT_EN adds input `preempt` (1 bit, level, emergency vehicle on main).
- With the macro:
  - While preempt=1, MAIN_G never exits.
  - On the first preempt cycle, SIDE_G jumps to SIDE_Y and PED_WALK jumps to CLR_IN. Yellow and clearance durations still run in full.
  - Requests stay latched and are served after preempt falls plus the remaining MAIN_MIN_GREEN time.
- Without the macro: the port is absent and behaviour is exactly as above.

Decomposition:
- Package tl_pkg holds:
  - lamp code constants (LAMP_RED=2'b00, LAMP_YEL=2'b01, LAMP_GRN=2'b10);
  - the state encoding for the 7 states;
  - the svc encoding (SIDE/PED).
- Sub-module tl_req_latch holds the sense counter plus the side_wait/ped_wait set/clear logic. It is instantiated once and takes clear strobes from the FSM.

Test Plan:
1. Reset with no requests for 50 cycles -> main_l=10, side_l=00, ped_l=0, phase=MAIN_G throughout; assert rst mid-SIDE_G -> main_l=10 asynchronously.
2. side_s high cycles 2-4 -> side_wait=1 at cycle 5; MAIN_Y cycles 8-10, CLR_OUT 11, SIDE_G 12-17, SIDE_Y 18-20, CLR_IN 21, MAIN_G at 22; side_wait=0 from 12.
3. side_s high only 2 cycles -> side_wait stays 0; no phase change over 40 cycles.
4. ped_req pulse at cycle 1 -> PED_WALK cycles 12-16 with ped_ack=1 only at 12; MAIN_G at 18; ped_req at cycle 14 -> ped_wait=1 after 14, second walk follows the next 8-cycle MAIN_G.
5. Side and ped both pending at the MAIN_G exit -> first service SIDE, next PED, then SIDE (alternation); the unserved flag is held throughout.
6. TL_PREEMPT_EN: preempt asserted at cycle 14 of scenario 2 -> SIDE_Y at 15-17, CLR_IN 18, MAIN_G from 19 held while preempt=1; safety invariant checked every cycle.

Source files
------------

// File: rtl/tl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tl_pkg
//  Description : Shared definitions for the junction phase scheduler:
//                lamp codes, the seven-state phase encoding (also driven out
//                on the phase port) and the service-selection encoding.
//  Optional    : TL_PREEMPT_EN is consumed by tl_phase_scheduler only.
//  Revision    : 1.0  initial release
// ============================================================================
package tl_pkg;

    // Lamp drive codes shared by the main and side heads.
    localparam logic [1:0] LAMP_RED = 2'b00;
    localparam logic [1:0] LAMP_YEL = 2'b01;
    localparam logic [1:0] LAMP_GRN = 2'b10;

    // Phase encoding; 3'd7 is unused and recovers to MAIN_G.
    typedef enum logic [2:0] {
        MAIN_G   = 3'd0,
        MAIN_Y   = 3'd1,
        CLR_OUT  = 3'd2,
        SIDE_G   = 3'd3,
        SIDE_Y   = 3'd4,
        PED_WALK = 3'd5,
        CLR_IN   = 3'd6
    } state_t;

    // Which requester the current excursion from MAIN_G is serving.
    typedef enum logic {
        SVC_PED  = 1'b0,
        SVC_SIDE = 1'b1
    } svc_t;

endpackage
`default_nettype wire

// File: rtl/tl_req_latch.sv
`default_nettype none
// ============================================================================
//  Module      : tl_req_latch
//  Description : Request front end. Debounces the side-road sensor with a
//                saturating run-length counter and holds the side/ped
//                request flags until the FSM strobes their clears.
//  Ports       : clk, rst        clock, async active-high reset
//                side_s, ped_req raw sensor level / button
//                side_clr        FSM is entering SIDE_G on this edge
//                ped_clr         FSM is entering PED_WALK on this edge
//                side_wait       latched side request
//                ped_wait        latched pedestrian request
//  Revision    : 1.0  initial release
// ============================================================================
module tl_req_latch #(
    parameter int SENSE_CYCLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic side_s,
    input  logic ped_req,
    input  logic side_clr,
    input  logic ped_clr,
    output logic side_wait,
    output logic ped_wait
);

    localparam int               c_sense_w   = $clog2(SENSE_CYCLES + 1);
    localparam logic [c_sense_w-1:0] c_sense_max = c_sense_w'(SENSE_CYCLES);

    logic [c_sense_w-1:0] r_sense;
    logic [c_sense_w-1:0] w_sense_next;
    logic                 w_side_set;

    // Run length of consecutive side_s-high cycles, saturating at the target.
    always_comb begin
        w_sense_next = '0;
        if (side_s) begin
            w_sense_next = (r_sense == c_sense_max) ? r_sense : r_sense + 1'b1;
        end
    end

    // A sustained presence keeps requesting, so a vehicle still on the loop
    // after its own green re-arms the flag.
    assign w_side_set = (w_sense_next == c_sense_max);

    // Clear has priority: a request landing on the service-entry edge is
    // absorbed by that service.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sense   <= '0;
            side_wait <= 1'b0;
            ped_wait  <= 1'b0;
        end else begin
            r_sense   <= w_sense_next;
            side_wait <= side_clr ? 1'b0 : (side_wait | w_side_set);
            ped_wait  <= ped_clr  ? 1'b0 : (ped_wait  | ped_req);
        end
    end

endmodule
`default_nettype wire

// File: rtl/tl_phase_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tl_phase_scheduler
//  Description : Main/side/pedestrian junction phase scheduler. Main road
//                owns right-of-way by default; latched side and pedestrian
//                requests are served in alternation when both are pending.
//                Lamp outputs are decoded from the next state and registered
//                so they change on the same edge as phase.
//  Ports       : clk, rst        clock, async active-high reset
//                side_s          side-road sensor level
//                ped_req         pedestrian button
//                preempt         emergency preemption (TL_PREEMPT_EN only)
//                main_l, side_l  lamp codes (10 green, 01 yellow, 00 red)
//                ped_l           walk lamp
//                side_wait       side request pending
//                ped_wait        pedestrian request pending
//                ped_ack         pulse on first PED_WALK cycle
//                phase           current state encoding
//  Macro       : TL_PREEMPT_EN adds the preempt input.
//  Revision    : 1.0  initial release
// ============================================================================
module tl_phase_scheduler
    import tl_pkg::*;
#(
    parameter int MAIN_MIN_GREEN = 8,
    parameter int YELLOW_T       = 3,
    parameter int ALL_RED_T      = 1,
    parameter int SIDE_GREEN_T   = 6,
    parameter int WALK_T         = 5,
    parameter int SENSE_CYCLES   = 3,
    parameter int CNT_W          = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       side_s,
    input  logic       ped_req,
`ifdef TL_PREEMPT_EN
    input  logic       preempt,
`endif
    output logic [1:0] main_l,
    output logic [1:0] side_l,
    output logic       ped_l,
    output logic       side_wait,
    output logic       ped_wait,
    output logic       ped_ack,
    output logic [2:0] phase
);

    // Timer value on the final cycle of each timed state.
    localparam logic [CNT_W-1:0] c_main_last = CNT_W'(MAIN_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] c_yel_last  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] c_clr_last  = CNT_W'(ALL_RED_T - 1);
    localparam logic [CNT_W-1:0] c_side_last = CNT_W'(SIDE_GREEN_T - 1);
    localparam logic [CNT_W-1:0] c_walk_last = CNT_W'(WALK_T - 1);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_timer;
    svc_t               r_svc;
    svc_t               r_last_served;
    svc_t               w_svc_sel;
    logic               w_entry;
    logic               w_side_clr;
    logic               w_ped_clr;
    logic               w_preempt;

`ifdef TL_PREEMPT_EN
    assign w_preempt = preempt;
`else
    assign w_preempt = 1'b0;
`endif

    // Requester chosen if MAIN_G exits this cycle: a lone flag wins outright,
    // a tie goes to whoever was not served last time.
    always_comb begin
        w_svc_sel = SVC_PED;
        if (side_wait && ped_wait) begin
            w_svc_sel = (r_last_served == SVC_SIDE) ? SVC_PED : SVC_SIDE;
        end else if (side_wait) begin
            w_svc_sel = SVC_SIDE;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            MAIN_G:   if (!w_preempt && (r_timer >= c_main_last) && (side_wait || ped_wait))
                          w_next = MAIN_Y;
            MAIN_Y:   if (r_timer == c_yel_last)  w_next = CLR_OUT;
            CLR_OUT:  if (r_timer == c_clr_last)  w_next = (r_svc == SVC_SIDE) ? SIDE_G : PED_WALK;
            SIDE_G:   if (w_preempt || (r_timer == c_side_last)) w_next = SIDE_Y;
            SIDE_Y:   if (r_timer == c_yel_last)  w_next = CLR_IN;
            PED_WALK: if (w_preempt || (r_timer == c_walk_last)) w_next = CLR_IN;
            CLR_IN:   if (r_timer == c_clr_last)  w_next = MAIN_G;
            default:  w_next = MAIN_G;
        endcase
    end

    assign w_entry    = (w_next != r_state);
    assign w_side_clr = w_entry && (w_next == SIDE_G);
    assign w_ped_clr  = w_entry && (w_next == PED_WALK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= MAIN_G;
            r_timer       <= '0;
            r_svc         <= SVC_PED;
            r_last_served <= SVC_PED;
            main_l        <= LAMP_GRN;
            side_l        <= LAMP_RED;
            ped_l         <= 1'b0;
            ped_ack       <= 1'b0;
        end else begin
            r_state <= w_next;

            // Timed states never count past their last value; MAIN_G holds
            // at its minimum so a long quiet period cannot wrap the timer.
            if (w_entry) begin
                r_timer <= '0;
            end else if ((r_state != MAIN_G) || (r_timer < c_main_last)) begin
                r_timer <= r_timer + 1'b1;
            end

            if ((r_state == MAIN_G) && w_entry) begin
                r_svc         <= w_svc_sel;
                r_last_served <= w_svc_sel;
            end

            main_l  <= (w_next == MAIN_G) ? LAMP_GRN :
                       (w_next == MAIN_Y) ? LAMP_YEL : LAMP_RED;
            side_l  <= (w_next == SIDE_G) ? LAMP_GRN :
                       (w_next == SIDE_Y) ? LAMP_YEL : LAMP_RED;
            ped_l   <= (w_next == PED_WALK);
            ped_ack <= w_ped_clr;
        end
    end

    assign phase = r_state;

    tl_req_latch #(
        .SENSE_CYCLES (SENSE_CYCLES)
    ) u_req_latch (
        .clk       (clk),
        .rst       (rst),
        .side_s    (side_s),
        .ped_req   (ped_req),
        .side_clr  (w_side_clr),
        .ped_clr   (w_ped_clr),
        .side_wait (side_wait),
        .ped_wait  (ped_wait)
    );

endmodule
`default_nettype wire

// File: tb/tb_tl_phase_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tl_phase_scheduler
//  Description : Self-checking bench for tl_phase_scheduler. Directed
//                scenarios plus a randomized run, all compared cycle by cycle
//                against a schedule-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tl_phase_scheduler;
    import tl_pkg::*;

    localparam int MIN   = 8;
    localparam int YEL   = 3;
    localparam int CLR   = 1;
    localparam int SGRN  = 6;
    localparam int WALK  = 5;
    localparam int SENSE = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       side_s = 1'b0;
    logic       ped_req = 1'b0;
    logic [1:0] main_l, side_l;
    logic       ped_l, side_wait, ped_wait, ped_ack;
    logic [2:0] phase;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: phase plus the cycle on which it was entered.
    logic [2:0] m_phase;
    int         m_entry;
    int         m_streak;
    logic       m_sw, m_pw, m_ack, m_svc_side, m_last_side;

    always #5 clk = ~clk;

    tl_phase_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .side_s    (side_s),
        .ped_req   (ped_req),
`ifdef TL_PREEMPT_EN
        .preempt   (1'b0),
`endif
        .main_l    (main_l),
        .side_l    (side_l),
        .ped_l     (ped_l),
        .side_wait (side_wait),
        .ped_wait  (ped_wait),
        .ped_ack   (ped_ack),
        .phase     (phase)
    );

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    endtask

    function automatic int dur(input logic [2:0] ph);
        case (ph)
            MAIN_Y, SIDE_Y:  return YEL;
            CLR_OUT, CLR_IN: return CLR;
            SIDE_G:          return SGRN;
            PED_WALK:        return WALK;
            default:         return MIN;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = MAIN_G; m_entry = 0; m_streak = 0;
        m_sw = 0; m_pw = 0; m_ack = 0; m_svc_side = 0; m_last_side = 0;
        cyc = 0;
    endtask

    // Advance the model across one clock edge given this cycle's inputs.
    task automatic model_step(input logic s, input logic p);
        int         in_ph;
        logic [2:0] nx;
        logic       sreq;
        m_streak = s ? ((m_streak < SENSE) ? m_streak + 1 : SENSE) : 0;
        sreq     = (m_streak == SENSE);
        in_ph    = cyc - m_entry + 1;
        nx       = m_phase;
        if (m_phase == MAIN_G) begin
            if (in_ph >= MIN && (m_sw || m_pw)) begin
                nx          = MAIN_Y;
                m_svc_side  = (m_sw && m_pw) ? !m_last_side : m_sw;
                m_last_side = m_svc_side;
            end
        end else if (in_ph >= dur(m_phase)) begin
            case (m_phase)
                MAIN_Y:   nx = CLR_OUT;
                CLR_OUT:  nx = m_svc_side ? SIDE_G : PED_WALK;
                SIDE_G:   nx = SIDE_Y;
                SIDE_Y:   nx = CLR_IN;
                PED_WALK: nx = CLR_IN;
                default:  nx = MAIN_G;
            endcase
        end
        m_ack = (nx != m_phase) && (nx == PED_WALK);
        m_sw  = (nx == SIDE_G   && m_phase != SIDE_G)   ? 1'b0 : (m_sw | sreq);
        m_pw  = (nx == PED_WALK && m_phase != PED_WALK) ? 1'b0 : (m_pw | p);
        if (nx != m_phase) m_entry = cyc + 1;
        m_phase = nx;
    endtask

    task automatic compare_all();
        logic [1:0] em, es;
        em = (m_phase == MAIN_G) ? 2'b10 : (m_phase == MAIN_Y) ? 2'b01 : 2'b00;
        es = (m_phase == SIDE_G) ? 2'b10 : (m_phase == SIDE_Y) ? 2'b01 : 2'b00;
        chk("phase",     {1'b0, phase}, {1'b0, m_phase});
        chk("main_l",    {2'b0, main_l}, {2'b0, em});
        chk("side_l",    {2'b0, side_l}, {2'b0, es});
        chk("ped_l",     {3'b0, ped_l},  {3'b0, (m_phase == PED_WALK)});
        chk("side_wait", {3'b0, side_wait}, {3'b0, m_sw});
        chk("ped_wait",  {3'b0, ped_wait},  {3'b0, m_pw});
        chk("ped_ack",   {3'b0, ped_ack},   {3'b0, m_ack});
        chk("safety", {3'b0, ((main_l != 2'b00) && (side_l != 2'b00)) ||
                             (ped_l && ((main_l | side_l) != 2'b00))}, 4'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1; side_s = 1'b0; ped_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        compare_all();
    endtask

    task automatic tick(input logic s, input logic p);
        @(negedge clk);
        side_s = s; ped_req = p;
        model_step(s, p);
        @(posedge clk);
        #1 cyc++;
        compare_all();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic s_lvl;

        // Idle: main keeps right-of-way with no requests.
        do_reset();
        for (int c = 0; c < 50; c++) tick(1'b0, 1'b0);
        chk("idle_phase", {1'b0, phase}, {1'b0, MAIN_G});

        // Side request, full side excursion.
        do_reset();
        for (int c = 0; c < 23; c++) begin
            tick(c >= 2 && c <= 4, 1'b0);
            if (cyc == 5)  chk("s2_sw5", {3'b0, side_wait}, 4'd1);
            if (cyc == 8)  chk("s2_my8", {1'b0, phase}, {1'b0, MAIN_Y});
            if (cyc == 11) chk("s2_co11", {1'b0, phase}, {1'b0, CLR_OUT});
            if (cyc == 12) chk("s2_sg12", {1'b0, phase}, {1'b0, SIDE_G});
            if (cyc == 12) chk("s2_sw12", {3'b0, side_wait}, 4'd0);
            if (cyc == 18) chk("s2_sy18", {1'b0, phase}, {1'b0, SIDE_Y});
            if (cyc == 21) chk("s2_ci21", {1'b0, phase}, {1'b0, CLR_IN});
            if (cyc == 22) chk("s2_mg22", {1'b0, phase}, {1'b0, MAIN_G});
        end

        // Asynchronous reset in the middle of SIDE_G.
        do_reset();
        for (int c = 0; c < 14; c++) tick(c >= 2 && c <= 4, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_main", {2'b0, main_l}, 4'b0010);
        chk("arst_side", {2'b0, side_l}, 4'b0000);
        chk("arst_phase", {1'b0, phase}, {1'b0, MAIN_G});

        // Short side pulse is ignored.
        do_reset();
        for (int c = 0; c < 40; c++) begin
            tick(c >= 2 && c <= 3, 1'b0);
            if (cyc == 40) chk("s3_sw", {3'b0, side_wait}, 4'd0);
        end

        // Pedestrian walk, then a request during the walk.
        do_reset();
        for (int c = 0; c < 32; c++) begin
            tick(1'b0, c == 1 || c == 14);
            if (cyc == 12) chk("s4_ack12", {3'b0, ped_ack}, 4'd1);
            if (cyc == 12) chk("s4_pw12", {1'b0, phase}, {1'b0, PED_WALK});
            if (cyc == 13) chk("s4_ack13", {3'b0, ped_ack}, 4'd0);
            if (cyc == 15) chk("s4_pwt15", {3'b0, ped_wait}, 4'd1);
            if (cyc == 18) chk("s4_mg18", {1'b0, phase}, {1'b0, MAIN_G});
            if (cyc == 30) chk("s4_pw30", {1'b0, phase}, {1'b0, PED_WALK});
        end

        // Both pending: SIDE, PED, SIDE.
        do_reset();
        for (int c = 0; c < 54; c++) begin
            tick((c <= 2) || (c >= 13 && c <= 15), c == 0);
            if (cyc == 12) chk("s5_sg12", {1'b0, phase}, {1'b0, SIDE_G});
            if (cyc == 12) chk("s5_pwt12", {3'b0, ped_wait}, 4'd1);
            if (cyc == 34) chk("s5_pw34", {1'b0, phase}, {1'b0, PED_WALK});
            if (cyc == 34) chk("s5_swt34", {3'b0, side_wait}, 4'd1);
            if (cyc == 52) chk("s5_sg52", {1'b0, phase}, {1'b0, SIDE_G});
        end

        // Randomized traffic.
        do_reset();
        s_lvl = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) s_lvl = ~s_lvl;
            tick(s_lvl, $urandom_range(0, 24) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
